// File: rtl/wb_regfile.sv
// Write-back register file: 32x32 GPRs with two combinational read ports, a registered commit trace and a commit counter.
// Optional macro REGFILE_BYPASS_EN makes the read ports return the in-flight write-back data in the same cycle.
module wb_regfile #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] wb_waddr,
  input  logic          wb_we,
  input  logic [DW-1:0] wb_wdata,
  input  logic [31:0]   wb_pc_i,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  output logic [31:0]   debug_wb_pc,
  output logic [3:0]    debug_wb_rf_wen,
  output logic [AW-1:0] debug_wb_rf_wnum,
  output logic [DW-1:0] debug_wb_rf_wdata,
  output logic [31:0]   commit_cnt
);

  logic [DW-1:0] regs_reg [NREG];
  logic [31:0]   commit_cnt_reg;
  logic          commit;

  // r0 is hard-wired to zero, so a write to it is not architecturally effective.
  assign commit = wb_we && (wb_waddr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (commit) begin
      regs_reg[wb_waddr] <= wb_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
      commit_cnt_reg    <= '0;
    end else begin
      // Bubbles still refresh pc/wnum/wdata; only wen marks a real commit.
      debug_wb_pc       <= wb_pc_i;
      debug_wb_rf_wen   <= {4{commit}};
      debug_wb_rf_wnum  <= wb_waddr;
      debug_wb_rf_wdata <= wb_wdata;
      if (commit) begin
        commit_cnt_reg <= commit_cnt_reg + 32'd1;
      end
    end
  end

  assign commit_cnt = commit_cnt_reg;

  function automatic logic [DW-1:0] read_port(input logic re, input logic [AW-1:0] addr);
    logic [DW-1:0] data;
    logic          bypass_hit;
    data = '0;
`ifdef REGFILE_BYPASS_EN
    bypass_hit = wb_we && (wb_waddr == addr);
`else
    bypass_hit = 1'b0;
`endif
    if (rst && re && (addr != '0)) begin
      data = bypass_hit ? wb_wdata : regs_reg[addr];
    end
    return data;
  endfunction

  assign rdata1 = read_port(re1, raddr1);
  assign rdata2 = read_port(re2, raddr2);

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus random write/read traffic against an array-based model.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [4:0]  wb_waddr;
  logic        wb_we;
  logic [31:0] wb_wdata;
  logic [31:0] wb_pc_i;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] commit_cnt;

  wb_regfile dut (
    .clk               (clk),
    .rst               (rst),
    .wb_waddr          (wb_waddr),
    .wb_we             (wb_we),
    .wb_wdata          (wb_wdata),
    .wb_pc_i           (wb_pc_i),
    .re1               (re1),
    .raddr1            (raddr1),
    .rdata1            (rdata1),
    .re2               (re2),
    .raddr2            (raddr2),
    .rdata2            (rdata2),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .commit_cnt        (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural state as the spec describes it.
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  logic [31:0] m_pc, m_wdata;
  logic [3:0]  m_wen;
  logic [4:0]  m_wnum;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 0; m_pc = 0; m_wen = 0; m_wnum = 0; m_wdata = 0;
  endtask

  function automatic logic [31:0] exp_read(input logic re, input logic [4:0] a);
    if (!rst || !re || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wb_we && wb_waddr == a) return wb_wdata;
`endif
    return m_regs[a];
  endfunction

  // One clock: drive, check reads before the edge, update model at the edge, check trace after.
  task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc,
                       input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2);
    wb_we = we; wb_waddr = wa; wb_wdata = wd; wb_pc_i = pc;
    re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
    #1;
    check("rdata1", rdata1, exp_read(r1, a1));
    check("rdata2", rdata2, exp_read(r2, a2));
    $display("cyc we=%0d wa=%0d wd=%08h r1=%0d/%0d:%08h r2=%0d/%0d:%08h cnt=%08h",
             we, wa, wd, r1, a1, rdata1, r2, a2, rdata2, commit_cnt);
    @(posedge clk);
    if (we && wa != 0) begin
      m_regs[wa] = wd;
      m_cnt = m_cnt + 1;
    end
    m_pc = pc; m_wen = (we && wa != 0) ? 4'hF : 4'h0; m_wnum = wa; m_wdata = wd;
    #1;
    check("trace_pc", debug_wb_pc, m_pc);
    check("trace_wen", {28'h0, debug_wb_rf_wen}, {28'h0, m_wen});
    check("trace_wnum", {27'h0, debug_wb_rf_wnum}, {27'h0, m_wnum});
    check("trace_wdata", debug_wb_rf_wdata, m_wdata);
    check("commit_cnt", commit_cnt, m_cnt);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    wb_we = 0; wb_waddr = 0; wb_wdata = 0; wb_pc_i = 0;
    re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 3;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_rdata2", rdata2, 32'h0);
    check("rst_cnt", commit_cnt, 32'h0);
    check("rst_wen", {28'h0, debug_wb_rf_wen}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Basic write then read next cycle
    cycle(1, 5'd3, 32'hDEADBEEF, 32'h1000, 0, 0, 0, 0);
    check("basic_wen", {28'h0, debug_wb_rf_wen}, 32'hF);
    check("basic_cnt", commit_cnt, 32'd1);
    cycle(0, 5'd0, 32'h0, 32'h1004, 1, 5'd3, 0, 0);
    check("basic_read_direct", rdata1, 32'hDEADBEEF);

    // r0 immunity
    cycle(1, 5'd0, 32'hFFFFFFFF, 32'h1008, 1, 5'd0, 0, 0);
    cycle(0, 5'd0, 32'h0, 32'h100C, 1, 5'd0, 1, 5'd0);

    // Same-cycle hazard on r7
    cycle(1, 5'd7, 32'h1, 32'h1010, 0, 0, 0, 0);
    cycle(1, 5'd7, 32'h2, 32'h1014, 0, 0, 1, 5'd7);
    cycle(0, 5'd0, 32'h0, 32'h1018, 0, 0, 1, 5'd7);

    // Read enables and dual port on same address
    cycle(0, 5'd0, 32'h0, 32'h101C, 0, 5'd3, 1, 5'd3);
    cycle(0, 5'd0, 32'h0, 32'h1020, 1, 5'd3, 1, 5'd3);
    check("dual_equal", rdata1, rdata2);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) wa = 5'd0;
      cycle(1'($urandom), wa, $urandom, $urandom,
            1'($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom));
    end

    // Counter wrap
    force dut.commit_cnt_reg = 32'hFFFFFFFF;
    #1;
    release dut.commit_cnt_reg;
    m_cnt = 32'hFFFFFFFF;
    cycle(1, 5'd9, 32'hA5A5A5A5, 32'h2000, 0, 0, 0, 0);
    check("wrap_cnt", commit_cnt, 32'h0);

    // Asynchronous reset mid-cycle
    cycle(1, 5'd5, 32'h12345678, 32'h3000, 0, 0, 0, 0);
    wb_we = 0; re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 5;
    #1;
    check("pre_rst_r5", rdata1, 32'h12345678);
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_rdata1", rdata1, 32'h0);
    check("async_rdata2", rdata2, 32'h0);
    check("async_pc", debug_wb_pc, 32'h0);
    check("async_wen", {28'h0, debug_wb_rf_wen}, 32'h0);
    check("async_wnum", {27'h0, debug_wb_rf_wnum}, 32'h0);
    check("async_wdata", debug_wb_rf_wdata, 32'h0);
    check("async_cnt", commit_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cycle(0, 5'd0, 32'h0, 32'h4000, 1, 5'd5, 1, 5'd3);
    cycle(1, 5'd6, 32'hCAFEF00D, 32'h4004, 0, 0, 0, 0);
    cycle(0, 5'd0, 32'h0, 32'h4008, 1, 5'd6, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
